// File: rtl/ysyx_23060124_pipe_fifo_regs_if.sv
// Handshake bundle for the pipeline FIFO stage: upstream push side, downstream pop side,
// flush and occupancy. The stage itself connects through the slave modport.
interface ysyx_23060124_pipe_fifo_regs_if #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             i_flush;
    logic [CW-1:0]    o_count;

    modport master (
        output i_valid, i_data, i_ready, i_flush,
        input  o_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_valid, i_data, i_ready, i_flush,
        output o_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/ysyx_23060124_pipe_fifo_regs.sv
// Registered pipeline stage built as a DEPTH-entry FIFO; o_ready and o_valid come only
// from the occupancy register, so there is no combinational path through the stage.
module ysyx_23060124_pipe_fifo_regs #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 2,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    ysyx_23060124_pipe_fifo_regs_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             pop;
    logic             not_full;
    logic             not_empty;
    logic [WIDTH-1:0] head;

    assign not_full  = (count < DEPTH_C);
    assign not_empty = (count != '0);

    // Full-ness uses the registered count, so a full stage refuses a push even while popping.
    assign push = bus.i_valid && not_full  && !bus.i_flush;
    assign pop  = bus.i_ready && not_empty && !bus.i_flush;

    assign head = mem[rd_ptr];

    assign bus.o_ready = not_full;
    assign bus.o_valid = not_empty;
    assign bus.o_count = count;
    assign bus.o_data  = (ZERO_IDLE && !not_empty) ? '0 : head;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.i_data;
                wr_ptr      <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
